// File: rtl/rr_packet_arbiter_pkg.sv
// arbiter_pkg: port indices, crossbar select codes and FSM states for the packet arbiter
package arbiter_pkg;
  localparam int NPORTS = 5;
  localparam int WEST = 0;
  localparam int EAST = 1;
  localparam int SOUTH = 2;
  localparam int NORTH = 3;
  localparam int LOCAL = 4;
  localparam logic [2:0] SEL_LOCAL = 3'd0;
  localparam logic [2:0] SEL_NORTH = 3'd1;
  localparam logic [2:0] SEL_SOUTH = 3'd2;
  localparam logic [2:0] SEL_EAST = 3'd3;
  localparam logic [2:0] SEL_WEST = 3'd4;
  localparam logic [2:0] SEL_NONE = 3'd5;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/rr_packet_arbiter_if.sv
// rr_packet_arbiter_if: request/flit handshake and grant signals of one router output port
interface rr_packet_arbiter_if;
  logic [4:0] request;
  logic [4:0] flit_valid;
  logic       out_ready;
  logic [4:0] grant_vec;
  logic [2:0] crossbar_control;
  logic [4:0] flit_ready;
  logic       out_valid;
  logic       last_flit;
  logic       busy;
  modport master (
    output request, flit_valid, out_ready,
    input  grant_vec, crossbar_control, flit_ready, out_valid, last_flit, busy
  );
  modport slave (
    input  request, flit_valid, out_ready,
    output grant_vec, crossbar_control, flit_ready, out_valid, last_flit, busy
  );
endinterface

// File: rtl/rr_packet_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first set bit from ptr upward wins
module rr_pick
  import arbiter_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] gnt,
  output logic [2:0] idx,
  output logic       any
);
  always_comb begin
    idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NPORTS]) idx = 3'((int'(ptr) + i) % NPORTS);
    any = |req;
    gnt = any ? 5'(1) << idx : '0;
  end
endmodule

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin output arbiter holding each grant for a whole packet
module rr_packet_arbiter
  import arbiter_pkg::*;
#(
  parameter int PACKET_SIZE = 32,
  parameter int FLIT_SIZE   = 4,
  parameter int NUM_PORTS   = 5
) (
  input logic clk,
  input logic reset,
  rr_packet_arbiter_if.slave bus
);
  localparam int FLITS = PACKET_SIZE / FLIT_SIZE;
  localparam int CW = $clog2(FLITS);
  state_t state, state_n;
  logic [4:0] grant, grant_n, pick_gnt;
  logic [2:0] rr_ptr, ptr_n, win, win_n, tail_ptr, pick_idx;
  logic [CW-1:0] flit_cnt, cnt_n;
  logic pick_any, fire, tail;
  assign bus.grant_vec = grant;
  assign bus.busy = state == SEND;
  assign bus.out_valid = bus.busy & |(bus.flit_valid & grant);
  assign bus.flit_ready = grant & {5{bus.out_ready}};
  assign fire = bus.out_valid & bus.out_ready;
  assign tail = fire & (flit_cnt == CW'(FLITS - 1));
  assign bus.last_flit = tail;
  assign tail_ptr = win == 3'(NUM_PORTS - 1) ? '0 : win + 3'd1;
  assign bus.crossbar_control = grant == 5'(1 << LOCAL) ? SEL_LOCAL :
                                grant == 5'(1 << NORTH) ? SEL_NORTH :
                                grant == 5'(1 << SOUTH) ? SEL_SOUTH :
                                grant == 5'(1 << EAST)  ? SEL_EAST  :
                                grant == 5'(1 << WEST)  ? SEL_WEST  : SEL_NONE;
  // one picker serves both the idle pick and the tail re-pick with the advanced pointer
  rr_pick u_pick (
    .req(bus.request),
    .ptr(bus.busy ? tail_ptr : rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n = rr_ptr;
    win_n = win;
    cnt_n = flit_cnt;
    if (!bus.busy && pick_any) begin
      state_n = SEND;
      grant_n = pick_gnt;
      win_n = pick_idx;
      cnt_n = '0;
    end else if (tail) begin
      state_n = pick_any ? SEND : IDLE;
      grant_n = pick_gnt;
      win_n = pick_idx;
      ptr_n = tail_ptr;
      cnt_n = '0;
    end else if (fire) begin
      cnt_n = flit_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
      win <= '0;
      flit_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      rr_ptr <= ptr_n;
      win <= win_n;
      flit_cnt <= cnt_n;
    end
endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
Output-port arbiter for one router output in the NoC. It shares the output among five input ports (local, north, south, east, west) using round-robin priority and holds each grant for a whole packet of PACKET_SIZE/FLIT_SIZE flits. It drives the crossbar select code and gates the per-flit valid/ready handshake between the winning input buffer and the downstream link.

Parameters:
PACKET_SIZE, 32, packet length in bits
FLIT_SIZE, 4, flit length in bits; FLITS = PACKET_SIZE/FLIT_SIZE (default 8); FLITS >= 2 required
NUM_PORTS, 5, number of requesters; fixed at 5

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
request  input  5  per-port packet request: bit4 local, bit3 north, bit2 south, bit1 east, bit0 west
flit_valid  input  5  per-port flit available at input buffer head
out_ready  input  1  downstream link can accept a flit this cycle
grant_vec  output  5  one-hot registered grant, same bit mapping as request
crossbar_control  output  3  crossbar select: local=0, north=1, south=2, east=3, west=4, none=5
flit_ready  output  5  per-port pop strobe, equal to grant_vec & {5{out_ready}}
out_valid  output  1  flit_valid of the granted port while SEND, else 0
last_flit  output  1  high in the cycle the tail flit transfers
busy  output  1  high in SEND

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, grant_vec=0, crossbar_control=5
  - rr_ptr=0, flit_cnt=0
  - out_valid, last_flit, flit_ready and busy all 0
- States: IDLE, SEND.
  - IDLE: on a clock edge with request!=0, pick a winner, load grant_vec, clear flit_cnt, go to SEND.
  - A request seen in cycle N produces grant_vec in cycle N+1. This one-cycle latency is the minimum.
  - IDLE with request==0: stay in IDLE.
- Winner pick is round-robin starting at bit index rr_ptr (0..4).
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo 5. The first set request bit wins.
  - rr_ptr=0 gives the order west, east, south, north, local.
- Transfer (fire) = busy & out_valid & out_ready. Each fire increments flit_cnt.
  - flit_cnt is $clog2(FLITS) bits wide and never exceeds FLITS-1.
- Tail: fire while flit_cnt==FLITS-1 asserts last_flit (combinational) and at that edge:
  - sets rr_ptr = (winner index + 1) mod 5;
  - re-picks using the updated pointer and the current request vector;
  - if any request is set, loads the new grant, clears flit_cnt and stays in SEND (no bubble);
  - if no request is set, clears grant_vec and goes to IDLE.
  - The previous winner may win again, but only if it is the sole requester.
- Within SEND:
  - Grant is locked. Changes on request, including deassertion by the winner, are ignored until the tail.
  - out_ready=0 or flit_valid[winner]=0 stalls: flit_cnt and grant are held; no timeout.
- crossbar_control is decoded combinationally from grant_vec. Any non-one-hot value is unreachable; the decode defaults to 5.
- rr_ptr updates only on a tail fire. It is unchanged by IDLE cycles.
- Reset asserted mid-packet aborts immediately. Partial-packet recovery is the input buffers' responsibility.

Decomposition:
- Package arbiter_pkg holds:
  - port index constants: WEST=0, EAST=1, SOUTH=2, NORTH=3, LOCAL=4;
  - select codes SEL_LOCAL..SEL_WEST=0..4 and SEL_NONE=5;
  - the state enum {IDLE, SEND}.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req[4:0], ptr[2:0].
  - Outputs: gnt[4:0] (one-hot), idx[2:0], any.
  - Instantiated once; used both for the IDLE pick and the tail re-pick.

Test Plan:
1. Reset mid-SEND (reset=0 at flit 3) -> grant_vec=0, crossbar_control=5, busy=0 in the same cycle; after release the next pick starts from rr_ptr=0.
2. Only request[3] (north), with flit_valid and out_ready held high:
   - grant_vec=01000 and crossbar_control=1 one cycle after the request;
   - 8 fires, last_flit on the 8th, then IDLE and crossbar_control=5.
3. request=11111 held, flit_valid and out_ready high -> grant order west, east, south, north, local, west; each grant lasts exactly 8 cycles with zero idle cycles between packets.
4. Grant to east, out_ready toggled 1,0,0,1,… -> flit_cnt advances only on out_ready=1 cycles; flit_ready[1] mirrors out_ready; the grant holds until the 8th fire.
5. Winner deasserts request and a higher-priority port asserts mid-packet -> grant is unchanged until the tail; the new port wins at the tail edge.
6. Sole requester west finishes its tail while still requesting -> it is re-granted immediately (rr_ptr=1, wrap search) with no IDLE cycle.
